// File: rtl/mux_rr_scheduler_pkg.sv
// Shared constants and types for the round-robin mux scheduler.
// Contents: data width, fixed channel count, selector width, reset value of
// the round-robin pointer, and the FSM state encoding.
package mux_rr_scheduler_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned NCH_FIXED = 4;
  localparam int unsigned SEL_W     = 2;

  // Pointer starts at the last channel so channel 0 is favoured first
  localparam logic [SEL_W-1:0] RR_RESET_LAST = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Handshake/bus bundle between the scheduler and its surroundings.
// master: scheduler side (drives ack, selector, captured word, valid, busy).
// slave : environment side (drives req, mux output y_in, out_ready).
interface mux_rr_scheduler_if
  import mux_rr_scheduler_pkg::*;
#(
  parameter int unsigned W = DATA_W
);

  logic [NCH_FIXED-1:0] req;
  logic [NCH_FIXED-1:0] ack;
  logic [SEL_W-1:0]     selector;
  logic [W-1:0]         y_in;
  logic [W-1:0]         out_data;
  logic [SEL_W-1:0]     out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  modport master (
    input  req, y_in, out_ready,
    output ack, selector, out_data, out_ch, out_valid, busy
  );

  modport slave (
    output req, y_in, out_ready,
    input  ack, selector, out_data, out_ch, out_valid, busy
  );

endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Ports: req (per-channel requests), last (previous grant),
//        grant (first requester after last, wrapping), any_req (req != 0).
module rr_priority_pick
  import mux_rr_scheduler_pkg::*;
(
  input  logic [NCH_FIXED-1:0] req,
  input  logic [SEL_W-1:0]     last,
  output logic [SEL_W-1:0]     grant,
  output logic                 any_req
);

  logic [SEL_W-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_idx   = '0;
    any_req = |req;
    // Scan farthest candidate first so the nearest one after last wins;
    // k = NCH_FIXED wraps onto last itself (lowest priority).
    for (int unsigned k = NCH_FIXED; k >= 1; k--) begin
      w_idx = last + SEL_W'(k);
      if (req[w_idx]) grant = w_idx;
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler around a 4:1 serial mux: grants a requesting channel,
// drives the mux selector, captures the mux output one cycle later and
// presents it on a valid/ready port.
// Ports: clk, reset (async, active-high), bus (master modport: req/ack,
//        selector, y_in, out_data/out_ch/out_valid/out_ready, busy).
module mux_rr_scheduler
  import mux_rr_scheduler_pkg::*;
#(
  parameter int unsigned W   = DATA_W,
  parameter int unsigned NCH = NCH_FIXED
)(
  input  logic              clk,
  input  logic              reset,
  mux_rr_scheduler_if.master bus
);

  // The selector is 2 bits wide, so only four channels are addressable
  if (NCH != NCH_FIXED) begin : g_nch_check
    $error("mux_rr_scheduler: NCH must be 4");
  end

  state_t               r_state;
  logic [SEL_W-1:0]     r_selector;
  logic [SEL_W-1:0]     r_last_grant;
  logic [SEL_W-1:0]     r_out_ch;
  logic [NCH_FIXED-1:0] r_ack;
  logic [W-1:0]         r_out_data;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [SEL_W-1:0]     w_grant;
  logic                 w_any_req;

  rr_priority_pick u_pick (
    .req     (bus.req),
    .last    (r_last_grant),
    .grant   (w_grant),
    .any_req (w_any_req)
  );

  // Control FSM; r_selector doubles as the committed grant for the transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_selector   <= '0;
      r_last_grant <= RR_RESET_LAST;
      r_out_ch     <= '0;
      r_ack        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_selector <= w_grant;
            r_busy     <= 1'b1;
            r_state    <= SEL;
          end
        end
        SEL: begin
          // Mux has settled on the committed selector; capture regardless of req
          r_out_data  <= bus.y_in;
          r_out_ch    <= r_selector;
          r_out_valid <= 1'b1;
          r_ack       <= NCH_FIXED'(1) << r_selector;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
            r_last_grant <= r_selector;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.selector  = r_selector;
  assign bus.ack       = r_ack;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: directed stimulus, transaction-level reference
// model compared on every falling edge, literal checks on key outputs, and an
// exhaustive sweep of the round-robin picker.
module tb_mux_rr_scheduler;
  import mux_rr_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux_rr_scheduler_if #(.W(4)) bus ();

  // Channel data sources and the 4:1 mux itself
  logic [3:0] data [4];
  assign bus.y_in = data[bus.selector];

  mux_rr_scheduler #(.W(4), .NCH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] p_req;
  logic [1:0] p_last;
  logic [1:0] p_grant;
  logic       p_any;

  rr_priority_pick u_pick_chk (
    .req     (p_req),
    .last    (p_last),
    .grant   (p_grant),
    .any_req (p_any)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Candidates in priority order after last; first requester wins
  function automatic logic [1:0] model_pick(input logic [3:0] r, input logic [1:0] last);
    int order[$];
    for (int k = 1; k <= 4; k++) order.push_back((int'(last) + k) % 4);
    foreach (order[i]) if (r[order[i]]) return 2'(order[i]);
    return 2'd0;
  endfunction

  // Reference model: a transaction progresses grant -> capture -> hand-off
  int         m_phase = 0;
  logic [1:0] m_sel   = 2'd0;
  logic [1:0] m_last  = 2'b11;
  logic [1:0] m_ch    = 2'd0;
  logic [3:0] m_data  = 4'd0;
  logic [3:0] m_ack   = 4'd0;
  logic       m_valid = 1'b0;
  logic       m_busy  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_sel = 2'd0; m_last = 2'b11; m_ch = 2'd0;
      m_data = 4'd0; m_ack = 4'd0; m_valid = 1'b0; m_busy = 1'b0;
    end else begin
      m_ack = 4'd0;
      if (m_phase == 0) begin
        if (bus.req != 4'd0) begin
          m_sel = model_pick(bus.req, m_last);
          m_busy = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_data = data[m_sel];
        m_ch = m_sel;
        m_valid = 1'b1;
        m_ack[m_sel] = 1'b1;
        m_phase = 2;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
        m_last = m_sel;
        m_busy = 1'b0;
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("selector",  int'(bus.selector),  int'(m_sel));
    check("ack",       int'(bus.ack),       int'(m_ack));
    check("out_data",  int'(bus.out_data),  int'(m_data));
    check("out_ch",    int'(bus.out_ch),    int'(m_ch));
    check("out_valid", int'(bus.out_valid), int'(m_valid));
    check("busy",      int'(bus.busy),      int'(m_busy));
  end

  int cap_ch[$];
  int cap_data[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic collect(input int n, input int budget);
    int cyc = 0;
    cap_ch.delete();
    cap_data.delete();
    while (cap_ch.size() < n && cyc < budget) begin
      tick(1);
      cyc++;
      if (bus.ack != 4'd0) begin
        check("ack_onehot", $countones(bus.ack), 1);
        check("ack_matches_ch", int'(bus.ack), 1 << bus.out_ch);
        cap_ch.push_back(int'(bus.out_ch));
        cap_data.push_back(int'(bus.out_data));
      end
    end
    check("capture_count", cap_ch.size(), n);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_ack",       int'(bus.ack), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_selector",  int'(bus.selector), 0);
    check("rst_out_data",  int'(bus.out_data), 0);
    check("rst_out_ch",    int'(bus.out_ch), 0);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  int ack_cnt;
  int vwait;

  initial begin
    bus.req = 4'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = 4'd0;

    // Picker sweep: 16 request patterns x 4 pointer values
    for (int l = 0; l < 4; l++) begin
      for (int r = 0; r < 16; r++) begin
        p_req = 4'(r);
        p_last = 2'(l);
        #1;
        check("pick_any", int'(p_any), int'(r != 0));
        if (r != 0) check("pick_grant", int'(p_grant), int'(model_pick(p_req, p_last)));
      end
    end
    // Hand-computed pins of the picker and its model
    p_req = 4'b1001; p_last = 2'd3; #1;
    check("pick_lit_wrap0", int'(p_grant), 0);
    check("model_lit_wrap0", int'(model_pick(4'b1001, 2'd3)), 0);
    p_req = 4'b1001; p_last = 2'd0; #1;
    check("pick_lit_wrap3", int'(p_grant), 3);
    check("model_lit_2", int'(model_pick(4'b0110, 2'd2)), 1);

    // Reset and idle
    tick(2);
    reset = 1'b0;
    tick(10);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_valid", int'(bus.out_valid), 0);

    // Single request from channel 2
    data[2] = 4'hA;
    bus.out_ready = 1'b1;
    bus.req = 4'b0100;
    tick(1);
    check("single_selector", int'(bus.selector), 2);
    check("single_busy", int'(bus.busy), 1);
    tick(1);
    check("single_data", int'(bus.out_data), 4'hA);
    check("single_ch", int'(bus.out_ch), 2);
    check("single_ack", int'(bus.ack), 4'b0100);
    check("single_valid", int'(bus.out_valid), 1);
    bus.req = 4'd0;
    tick(1);
    check("single_valid_drop", int'(bus.out_valid), 0);
    check("single_ack_drop", int'(bus.ack), 0);

    // Request dropped during the settle cycle is still captured
    tick(2);
    data[1] = 4'h7;
    bus.req = 4'b0010;
    tick(1);
    bus.req = 4'd0;
    tick(1);
    check("drop_data", int'(bus.out_data), 7);
    check("drop_ch", int'(bus.out_ch), 1);
    tick(3);

    // Fresh pointer, then all four requesting
    pulse_reset();
    for (int i = 0; i < 4; i++) data[i] = 4'(i + 1);
    bus.req = 4'b1111;
    collect(5, 30);
    bus.req = 4'd0;
    if (cap_ch.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_ch", cap_ch[i], i % 4);
        check("rr_data", cap_data[i], (i % 4) + 1);
      end
    end
    tick(3);

    // Backpressure on channel 0
    data[0] = 4'h5;
    bus.out_ready = 1'b0;
    bus.req = 4'b0001;
    ack_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (bus.ack != 4'd0) ack_cnt++;
      if (i >= 1) begin
        check("bp_valid", int'(bus.out_valid), 1);
        check("bp_data", int'(bus.out_data), 5);
        check("bp_selector", int'(bus.selector), 0);
      end
    end
    bus.req = 4'd0;
    bus.out_ready = 1'b1;
    tick(1);
    check("bp_release", int'(bus.out_valid), 0);
    check("bp_ack_count", ack_cnt, 1);
    tick(2);

    // Wrap: move pointer to 3, then alternate between channels 0 and 3
    data[3] = 4'hC;
    data[0] = 4'h3;
    bus.req = 4'b1000;
    collect(1, 10);
    if (cap_ch.size() == 1) check("wrap_first", cap_ch[0], 3);
    bus.req = 4'b1001;
    collect(4, 30);
    bus.req = 4'd0;
    if (cap_ch.size() == 4) begin
      check("wrap_ch0", cap_ch[0], 0);
      check("wrap_ch1", cap_ch[1], 3);
      check("wrap_ch2", cap_ch[2], 0);
      check("wrap_ch3", cap_ch[3], 3);
      check("wrap_d1", cap_data[1], 4'hC);
    end
    tick(3);

    // Reset while a word is held
    bus.out_ready = 1'b0;
    bus.req = 4'b0001;
    vwait = 0;
    while (!bus.out_valid && vwait < 10) begin
      tick(1);
      vwait++;
    end
    check("hold_reached", int'(bus.out_valid), 1);
    pulse_reset();
    bus.out_ready = 1'b1;
    bus.req = 4'b1001;
    collect(1, 10);
    if (cap_ch.size() == 1) check("post_rst_first", cap_ch[0], 0);
    bus.req = 4'b1000;
    collect(1, 10);
    if (cap_ch.size() == 1) check("post_rst_ch3", cap_ch[0], 3);
    bus.req = 4'd0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
